// File: rtl/branch_npc_unit.sv
// branch_npc_unit
//   Next-PC selection with a direct-mapped branch target buffer (BTB) and
//   2-bit saturating counters. The BTB is looked up with the fetch PC and
//   trained with the branch that resolves in EX.
//
//   Ports
//     clk, rst          clock; async active-high reset
//     pred_en           1 = use BTB prediction, 0 = static not-taken
//     pc_f              fetch PC
//     jal_d/jal_target  JAL redirect from ID
//     jalr_e/jalr_target JALR redirect from EX
//     br_e/br_taken_e   conditional branch in EX and its outcome
//     br_target/pc_e    resolved target and EX PC
//     pred_e/pred_target_e  prediction carried down from fetch
//     pc_in             next PC
//     pred_f/pred_target_f  fetch-stage prediction
//     mispredict        EX branch was mispredicted (flush F/D)
//     stat_br/stat_miss resolved branches / mispredictions (wrapping)
module branch_npc_unit #(
  parameter int ENTRIES = 64,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_en,
  input  logic [31:0]       pc_f,
  input  logic              jal_d,
  input  logic [31:0]       jal_target,
  input  logic              jalr_e,
  input  logic [31:0]       jalr_target,
  input  logic              br_e,
  input  logic              br_taken_e,
  input  logic [31:0]       br_target,
  input  logic [31:0]       pc_e,
  input  logic              pred_e,
  input  logic [31:0]       pred_target_e,
  output logic [31:0]       pc_in,
  output logic              pred_f,
  output logic [31:0]       pred_target_f,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]             r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
  logic [ENTRIES-1:0][31:0]       r_target;
  logic [ENTRIES-1:0][1:0]        r_cnt;
  logic [STAT_W-1:0]              r_stat_br;
  logic [STAT_W-1:0]              r_stat_miss;

  logic [IDX_W-1:0] w_idx_f, w_idx_e;
  logic [TAG_W-1:0] w_tag_f, w_tag_e;
  logic             w_hit_f, w_hit_e;
  logic [31:0]      w_pc_f4, w_pc_e4;

  assign w_idx_f = pc_f[IDX_W+1:2];
  assign w_tag_f = pc_f[31:IDX_W+2];
  assign w_idx_e = pc_e[IDX_W+1:2];
  assign w_tag_e = pc_e[31:IDX_W+2];

  // Both lookups read the registered table, so a same-cycle update to the
  // fetch index is only visible from the next cycle on.
  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  assign pred_f        = pred_en & w_hit_f & r_cnt[w_idx_f][1];
  assign pred_target_f = w_hit_f ? r_target[w_idx_f] : 32'h0;

  // A taken branch predicted taken to the wrong target is also a miss.
  assign mispredict = br_e & ((br_taken_e != pred_e) |
                              (br_taken_e & pred_e & (pred_target_e != br_target)));

  assign w_pc_f4 = pc_f + 32'd4;
  assign w_pc_e4 = pc_e + 32'd4;

  // Older instructions redirect first: EX over ID over F.
  always_comb begin
    pc_in = w_pc_f4;
    if (jalr_e)                       pc_in = jalr_target;
    else if (mispredict && br_taken_e) pc_in = br_target;
    else if (mispredict)               pc_in = w_pc_e4;
    else if (jal_d)                    pc_in = jal_target;
    else if (pred_f)                   pc_in = pred_target_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_tag       <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
      r_stat_br   <= '0;
      r_stat_miss <= '0;
    end else if (br_e) begin
      r_stat_br <= r_stat_br + 1'b1;
      if (mispredict) r_stat_miss <= r_stat_miss + 1'b1;
      if (w_hit_e) begin
        if (br_taken_e) begin
          r_target[w_idx_e] <= br_target;
          if (r_cnt[w_idx_e] != 2'b11) r_cnt[w_idx_e] <= r_cnt[w_idx_e] + 2'b01;
        end else if (r_cnt[w_idx_e] != 2'b00) begin
          r_cnt[w_idx_e] <= r_cnt[w_idx_e] - 2'b01;
        end
      end else if (br_taken_e) begin
        // Miss + taken: take over the slot, start weakly taken.
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= br_target;
        r_cnt[w_idx_e]    <= 2'b10;
      end
    end
  end

  assign stat_br   = r_stat_br;
  assign stat_miss = r_stat_miss;

endmodule

// File: tb/tb_branch_npc_unit.sv
module tb_branch_npc_unit;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam int STAT_W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic pred_en, jal_d, jalr_e, br_e, br_taken_e, pred_e;
  logic [31:0] pc_f, jal_target, jalr_target, br_target, pc_e, pred_target_e;
  logic [31:0] pc_in, pred_target_f;
  logic pred_f, mispredict;
  logic [STAT_W-1:0] stat_br, stat_miss;

  always #5 clk = ~clk;

  branch_npc_unit #(.ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .pred_en(pred_en), .pc_f(pc_f),
    .jal_d(jal_d), .jal_target(jal_target), .jalr_e(jalr_e), .jalr_target(jalr_target),
    .br_e(br_e), .br_taken_e(br_taken_e), .br_target(br_target), .pc_e(pc_e),
    .pred_e(pred_e), .pred_target_e(pred_target_e), .pc_in(pc_in), .pred_f(pred_f),
    .pred_target_f(pred_target_f), .mispredict(mispredict),
    .stat_br(stat_br), .stat_miss(stat_miss)
  );

  // Reference model: BTB as plain arrays, counters as integers 0..3.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  logic [STAT_W-1:0] m_br, m_miss;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tg(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[ix(pc)] && (m_tag[ix(pc)] == tg(pc));
  endfunction

  function automatic bit exp_misp();
    if (!br_e) return 1'b0;
    if (br_taken_e != pred_e) return 1'b1;
    return br_taken_e && pred_e && (pred_target_e != br_target);
  endfunction

  // {pc_in, pred_f, pred_target_f, mispredict}
  function automatic logic [65:0] exp_out();
    bit          pf;
    logic [31:0] pt, npc;
    bit          mp;
    pf = pred_en && m_hit(pc_f) && (m_cnt[ix(pc_f)] >= 2);
    pt = m_hit(pc_f) ? m_target[ix(pc_f)] : 32'h0;
    mp = exp_misp();
    if (jalr_e)                  npc = jalr_target;
    else if (mp && br_taken_e)   npc = br_target;
    else if (mp)                 npc = pc_e + 32'd4;
    else if (jal_d)              npc = jal_target;
    else if (pf)                 npc = pt;
    else                         npc = pc_f + 32'd4;
    return {npc, pf, pt, mp};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_cnt[i] = 0;
    end
    m_br = '0; m_miss = '0;
  endtask

  // Advance one clock edge; the model trains with the inputs seen at the edge.
  task automatic tick();
    bit b, t, mp;
    logic [31:0] pe, bt;
    int k;
    b = br_e; t = br_taken_e; pe = pc_e; bt = br_target; mp = exp_misp();
    @(posedge clk);
    if (!rst && b) begin
      m_br = m_br + 1;
      if (mp) m_miss = m_miss + 1;
      k = ix(pe);
      if (m_hit(pe)) begin
        if (t) begin
          m_target[k] = bt;
          m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
        end else begin
          m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
        end
      end else if (t) begin
        m_valid[k] = 1; m_tag[k] = tg(pe); m_target[k] = bt; m_cnt[k] = 2;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] pcf);
    pred_en = 1; pc_f = pcf; jal_d = 0; jal_target = 0; jalr_e = 0; jalr_target = 0;
    br_e = 0; br_taken_e = 0; br_target = 0; pc_e = 0; pred_e = 0; pred_target_e = 0;
  endtask

  task automatic set_br(input logic [31:0] pe, input bit t, input logic [31:0] bt,
                        input bit pp, input logic [31:0] pt);
    br_e = 1; pc_e = pe; br_taken_e = t; br_target = bt; pred_e = pp; pred_target_e = pt;
  endtask

  task automatic test_reset();
    rst = 1; idle(32'h100); model_clear();
    #3;
    n_cmp++;
    if ({pc_in, pred_f} !== {32'h104, 1'b0}) begin
      n_bad++; $display("FAIL reset_out got pc_in=%h pred_f=%b exp 00000104/0", pc_in, pred_f);
    end
    n_cmp++;
    if ({stat_br, stat_miss} !== 64'h0) begin
      n_bad++; $display("FAIL reset_stats got %h/%h exp 0/0", stat_br, stat_miss);
    end
    @(negedge clk); rst = 0;
    tick();
  endtask

  task automatic test_train();
    idle(32'h1000); set_br(32'h200, 1, 32'h80, 0, 32'h0);
    #2;
    n_cmp++;
    if ({mispredict, pc_in} !== {1'b1, 32'h80} || {pc_in, pred_f, pred_target_f, mispredict} !== exp_out()) begin
      n_bad++; $display("FAIL train_redirect got misp=%b pc_in=%h exp 1/00000080", mispredict, pc_in);
    end
    tick();
    idle(32'h200); #2;
    n_cmp++;
    if ({pred_f, pred_target_f, pc_in} !== {1'b1, 32'h80, 32'h80}) begin
      n_bad++; $display("FAIL train_lookup got pred=%b tgt=%h pc_in=%h exp 1/80/80", pred_f, pred_target_f, pc_in);
    end
    n_cmp++;
    if ({stat_br, stat_miss} !== {32'd1, 32'd1}) begin
      n_bad++; $display("FAIL train_stats got %0d/%0d exp 1/1", stat_br, stat_miss);
    end
  endtask

  task automatic test_decay();
    // Entry 0x200 is at cnt=2 from the previous test.
    idle(32'h200); set_br(32'h200, 0, 32'h0, 1, 32'h80); #2;
    n_cmp++;
    if ({mispredict, pc_in} !== {1'b1, 32'h204}) begin
      n_bad++; $display("FAIL decay_nt1 got misp=%b pc_in=%h exp 1/00000204", mispredict, pc_in);
    end
    tick();
    idle(32'h200); #2;
    n_cmp++;
    if (pred_f !== 1'b0) begin
      n_bad++; $display("FAIL decay_cnt1 got pred_f=%b exp 0", pred_f);
    end
    set_br(32'h200, 0, 32'h0, 0, 32'h0); tick();
    idle(32'h200); set_br(32'h200, 0, 32'h0, 0, 32'h0); #2;
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_bad++; $display("FAIL decay_nt3 got misp=%b exp 0", mispredict);
    end
    tick();
    // One taken from cnt=0 reaches 1: still not predicted.
    idle(32'h200); set_br(32'h200, 1, 32'h80, 0, 32'h0); tick();
    idle(32'h200); #2;
    n_cmp++;
    if ({pred_f, pred_target_f} !== {1'b0, 32'h80}) begin
      n_bad++; $display("FAIL decay_floor got pred=%b tgt=%h exp 0/80", pred_f, pred_target_f);
    end
    set_br(32'h200, 1, 32'h80, 0, 32'h0); tick();
    idle(32'h200); #2;
    n_cmp++;
    if ({pred_f, pc_in, stat_br, stat_miss} !== {1'b1, 32'h80, 32'd6, 32'd4}) begin
      n_bad++; $display("FAIL decay_retrain got pred=%b pc_in=%h st=%0d/%0d exp 1/80/6/4", pred_f, pc_in, stat_br, stat_miss);
    end
  endtask

  task automatic test_priority();
    idle(32'h600);
    jalr_e = 1; jalr_target = 32'hA00; jal_d = 1; jal_target = 32'hC00;
    set_br(32'h600, 1, 32'hB00, 0, 32'h0); #1;
    n_cmp++;
    if (pc_in !== 32'hA00) begin
      n_bad++; $display("FAIL prio_jalr got %h exp 00000a00", pc_in);
    end
    jalr_e = 0; #1;
    n_cmp++;
    if (pc_in !== 32'hB00) begin
      n_bad++; $display("FAIL prio_br_taken got %h exp 00000b00", pc_in);
    end
    br_taken_e = 0; pred_e = 1; pred_target_e = 32'hB00; #1;
    n_cmp++;
    if (pc_in !== 32'h604) begin
      n_bad++; $display("FAIL prio_br_nt got %h exp 00000604", pc_in);
    end
    br_e = 0; #1;
    n_cmp++;
    if (pc_in !== 32'hC00) begin
      n_bad++; $display("FAIL prio_jal got %h exp 00000c00", pc_in);
    end
    // br_e=0 with both jumps asserted must not train or count.
    jalr_e = 1; tick();
    idle(32'h600); #1;
    n_cmp++;
    if ({pc_in, pred_f, pred_target_f, mispredict} !== exp_out() || {stat_br, stat_miss} !== {m_br, m_miss}) begin
      n_bad++; $display("FAIL prio_nobr got pc_in=%h st=%0d/%0d", pc_in, stat_br, stat_miss);
    end
  endtask

  task automatic test_target();
    idle(32'h0); set_br(32'h700, 1, 32'h300, 0, 32'h0); tick();
    idle(32'h0); set_br(32'h700, 1, 32'h340, 1, 32'h300); #2;
    n_cmp++;
    if ({mispredict, pc_in} !== {1'b1, 32'h340}) begin
      n_bad++; $display("FAIL tgt_misp got misp=%b pc_in=%h exp 1/00000340", mispredict, pc_in);
    end
    tick();
    idle(32'h700); #2;
    n_cmp++;
    if ({pred_f, pred_target_f} !== {1'b1, 32'h340}) begin
      n_bad++; $display("FAIL tgt_update got pred=%b tgt=%h exp 1/00000340", pred_f, pred_target_f);
    end
  endtask

  task automatic test_alias();
    idle(32'h0); set_br(32'h000, 1, 32'h900, 0, 32'h0); tick();
    idle(32'h0); set_br(32'h100, 1, 32'h980, 0, 32'h0); tick();
    idle(32'h000); #1;
    n_cmp++;
    if ({pred_f, pred_target_f, pc_in} !== {1'b0, 32'h0, 32'h4}) begin
      n_bad++; $display("FAIL alias_miss got pred=%b tgt=%h pc_in=%h exp 0/0/4", pred_f, pred_target_f, pc_in);
    end
    pc_f = 32'h100; #1;
    n_cmp++;
    if ({pred_f, pred_target_f} !== {1'b1, 32'h980}) begin
      n_bad++; $display("FAIL alias_hit got pred=%b tgt=%h exp 1/00000980", pred_f, pred_target_f);
    end
    // Same index updated this cycle: fetch still sees the old target.
    set_br(32'h100, 1, 32'h990, 1, 32'h980); #1;
    n_cmp++;
    if ({pred_target_f, pc_in} !== {32'h980, 32'h990}) begin
      n_bad++; $display("FAIL no_bypass got tgt=%h pc_in=%h exp 980/990", pred_target_f, pc_in);
    end
    tick();
    idle(32'h100); #1;
    n_cmp++;
    if (pred_target_f !== 32'h990) begin
      n_bad++; $display("FAIL bypass_after got %h exp 00000990", pred_target_f);
    end
  endtask

  task automatic test_wrap();
    idle(32'hFFFF_FFFC); #1;
    n_cmp++;
    if (pc_in !== 32'h0) begin
      n_bad++; $display("FAIL wrap_f got %h exp 00000000", pc_in);
    end
    set_br(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40); #1;
    n_cmp++;
    if ({mispredict, pc_in} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL wrap_e got misp=%b pc_in=%h exp 1/0", mispredict, pc_in);
    end
    tick();
    // Static mode: prediction suppressed even on a strong hit.
    idle(32'h100); pred_en = 0; #1;
    n_cmp++;
    if ({pred_f, pred_target_f, pc_in} !== {1'b0, 32'h990, 32'h104}) begin
      n_bad++; $display("FAIL pred_off got pred=%b tgt=%h pc_in=%h exp 0/990/104", pred_f, pred_target_f, pc_in);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] pe;
    pool = '{32'h000, 32'h100, 32'h204, 32'h304, 32'h1000, 32'h2204, 32'hFFFF_FFFC, 32'h40};
    for (int c = 0; c < 400; c++) begin
      idle(pool[$urandom_range(0, 7)]);
      pred_en = ($urandom_range(0, 7) != 0);
      jal_d = ($urandom_range(0, 7) == 0); jal_target = $urandom & 32'hFFFF_FFFC;
      jalr_e = ($urandom_range(0, 9) == 0); jalr_target = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) < 6) begin
        pe = pool[$urandom_range(0, 7)];
        set_br(pe, $urandom_range(0, 1), pool[$urandom_range(0, 7)] + 32'h800, 0, 32'h0);
        if ($urandom_range(0, 3) != 0) begin
          pred_e = m_hit(pe) && (m_cnt[ix(pe)] >= 2);
          pred_target_e = m_hit(pe) ? m_target[ix(pe)] : 32'h0;
        end else begin
          pred_e = $urandom_range(0, 1); pred_target_e = pool[$urandom_range(0, 7)] + 32'h800;
        end
      end
      #2;
      n_cmp++;
      if ({pc_in, pred_f, pred_target_f, mispredict} !== exp_out()) begin
        n_bad++; $display("FAIL rand_out c=%0d got %h exp %h", c, {pc_in, pred_f, pred_target_f, mispredict}, exp_out());
      end
      tick();
      n_cmp++;
      if ({stat_br, stat_miss} !== {m_br, m_miss}) begin
        n_bad++; $display("FAIL rand_stats c=%0d got %0d/%0d exp %0d/%0d", c, stat_br, stat_miss, m_br, m_miss);
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle(32'h0); set_br(32'h400, 1, 32'h500, 0, 32'h0); #2;
    rst = 1; model_clear(); #1;
    n_cmp++;
    if ({stat_br, stat_miss} !== 64'h0) begin
      n_bad++; $display("FAIL mid_rst_stats got %0d/%0d exp 0/0", stat_br, stat_miss);
    end
    tick();
    #2; rst = 0;
    idle(32'h400); #1;
    n_cmp++;
    if ({pred_f, pred_target_f, pc_in, stat_br} !== {1'b0, 32'h0, 32'h404, 32'd0}) begin
      n_bad++; $display("FAIL mid_rst_discard got pred=%b tgt=%h pc_in=%h br=%0d exp 0/0/404/0", pred_f, pred_target_f, pc_in, stat_br);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_decay();
    test_priority();
    test_target();
    test_alias();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
